ctrl_seq: RTL and testbench
===========================

CTRL_SEQ -- requirements
Module: ctrl_seq

Interface
REQ-001 SHALL have port clk, input, 1 bit: single system clock, all state updates on rising edge.
REQ-002 SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-003 SHALL have port run, input, 1 bit: fetch enable, sampled only in T0.
REQ-004 SHALL have port ir_in, input, 16 bits: instruction register contents, with opcode = ir_in[15:12].
REQ-005 SHALL have port zero_flag, input, 1 bit: accumulator-zero flag, used only with CTRL_JZ_EN.
REQ-006 SHALL have output ports pc_oe, pc_inc, pc_load, mar_write, ram_read, ram_write, ir_write, ir_oe, a_write, a_oe, b_write, alu_oe, alu_sub and out_write, each 1 bit: datapath control strobes.
REQ-007 SHALL have port halted, output, 1 bit: machine stopped.
REQ-008 SHALL have port tstate, output, 3 bits: current state encoding, for debug.

Function
REQ-009 SHALL implement states T0, T1, T2, T3, T4 and HALT, with all strobes decoded combinationally from registered state and opcode (Moore-style).
REQ-010 SHALL in T0 assert pc_oe and mar_write, advance to T1 if run=1, and otherwise hold T0 with all strobes low.
REQ-011 SHALL in T1 assert ram_read, ir_write and pc_inc, then go to T2.
REQ-012 SHALL decode the opcode from T2 onward and return to T0 after the last active step, so instruction length is 3-5 cycles.
REQ-013 SHALL sequence NOP 0x0: T2 with no strobes, then T0.
REQ-014 SHALL sequence LDA 0x1: T2 ir_oe and mar_write; T3 ram_read and a_write; then T0.
REQ-015 SHALL sequence ADD 0x2: T2 ir_oe and mar_write; T3 ram_read and b_write; T4 alu_oe and a_write; then T0.
REQ-016 SHALL sequence SUB 0x3: same as ADD, plus alu_sub asserted in T4 only.
REQ-017 SHALL sequence STA 0x4: T2 ir_oe and mar_write; T3 a_oe and ram_write; then T0.
REQ-018 SHALL sequence LDI 0x5: T2 ir_oe and a_write; then T0. JMP 0x6: T2 ir_oe and pc_load; then T0.
REQ-019 SHALL sequence OUT 0xE: T2 a_oe and out_write; then T0.
REQ-020 SHALL on HLT 0xF go from T2 to HALT, where halted=1, all strobes are 0, and the block stays until rst regardless of run.
REQ-021 SHALL treat opcodes 0x7-0xD as NOP, except 0x7 when CTRL_JZ_EN is defined.
REQ-022 SHALL assert at most one of pc_oe, ir_oe, a_oe, alu_oe or ram_read per cycle.

Reset
REQ-023 SHALL on rst=1 at a clock edge set state to T0 and halted to 0, aborting any in-progress instruction.
REQ-024 SHALL hold all strobes at 0 while rst=1, overriding the T0 decode.

Configuration
REQ-025 SHALL, with CTRL_JZ_EN defined, execute opcode 0x7 as JZ: in T2 assert ir_oe and pc_load if zero_flag=1, with no strobes otherwise; then T0.
REQ-026 SHALL, without CTRL_JZ_EN, treat 0x7 as NOP and ignore zero_flag.

Structure
REQ-027 SHALL take opcode localparams and state encodings from a shared package ctrl_pkg.
REQ-028 SHALL place the strobe decode, as a function of state and opcode, in a combinational sub-module ctrl_decode.

Verification
REQ-029 SHALL cover reset then run=1 with ir_in=0x1005 (LDA): tstate T0→T1→T2→T3→T0, with a_write high only in T3.
REQ-030 SHALL cover ADD 0x2008 then SUB 0x3008: alu_sub=1 only in the SUB T4 cycle, and both take 5 cycles.
REQ-031 SHALL cover run=0 in T0 for 4 cycles: tstate stays T0 and all strobes stay 0 (pc_oe and mar_write are gated while run=0).
REQ-032 SHALL cover HLT 0xF000: halted=1 from the cycle after T2, held with run toggling, and cleared by rst=1 for 1 cycle.
REQ-033 SHALL cover rst=1 asserted during ADD T3: next state T0, and strobes 0 during the reset cycle.
REQ-034 SHALL cover 0x7010 with zero_flag 1 then 0: pc_load is 1 then 0 with CTRL_JZ_EN, and 0 in both cases without it; the one-bus-driver check runs throughout.

Source files
------------

// File: rtl/ctrl_pkg.sv
// Shared definitions for the ctrl_seq microsequencer.
// Covers state encodings, opcodes, the strobe bundle and instruction-length helpers.
package ctrl_pkg;

  typedef enum logic [2:0] {
    StT0   = 3'd0,
    StT1   = 3'd1,
    StT2   = 3'd2,
    StT3   = 3'd3,
    StT4   = 3'd4,
    StHalt = 3'd5
  } state_e;

  localparam logic [3:0] OpNop = 4'h0;
  localparam logic [3:0] OpLda = 4'h1;
  localparam logic [3:0] OpAdd = 4'h2;
  localparam logic [3:0] OpSub = 4'h3;
  localparam logic [3:0] OpSta = 4'h4;
  localparam logic [3:0] OpLdi = 4'h5;
  localparam logic [3:0] OpJmp = 4'h6;
  localparam logic [3:0] OpJz  = 4'h7;
  localparam logic [3:0] OpOut = 4'hE;
  localparam logic [3:0] OpHlt = 4'hF;

  typedef struct packed {
    logic pc_oe;
    logic pc_inc;
    logic pc_load;
    logic mar_write;
    logic ram_read;
    logic ram_write;
    logic ir_write;
    logic ir_oe;
    logic a_write;
    logic a_oe;
    logic b_write;
    logic alu_oe;
    logic alu_sub;
    logic out_write;
  } strobes_t;

  // Instructions with a memory operand need T3; ALU ops also need T4.
  function automatic logic uses_t3(logic [3:0] op);
    return (op == OpLda) || (op == OpAdd) || (op == OpSub) || (op == OpSta);
  endfunction

  function automatic logic uses_t4(logic [3:0] op);
    return (op == OpAdd) || (op == OpSub);
  endfunction

endpackage

// File: rtl/ctrl_decode.sv
// Combinational strobe decode from state and opcode.
// Optional feature macro: CTRL_JZ_EN (opcode 0x7 executes as JZ).
module ctrl_decode
  import ctrl_pkg::*;
(
  input  state_e      state,
  input  logic [3:0]  opcode,
  input  logic        run,
  input  logic        rst,
  input  logic        zero_flag,
  output strobes_t    strb
);

`ifndef CTRL_JZ_EN
  logic unused_zero_flag;
  assign unused_zero_flag = zero_flag;
`endif

  always_comb begin
    strb = '0;
    if (!rst) begin
      case (state)
        StT0: begin
          // Fetch address only goes out when the machine is actually fetching.
          strb.pc_oe     = run;
          strb.mar_write = run;
        end
        StT1: begin
          strb.ram_read = 1'b1;
          strb.ir_write = 1'b1;
          strb.pc_inc   = 1'b1;
        end
        StT2: begin
          case (opcode)
            OpLda, OpAdd, OpSub, OpSta: begin
              strb.ir_oe     = 1'b1;
              strb.mar_write = 1'b1;
            end
            OpLdi: begin
              strb.ir_oe   = 1'b1;
              strb.a_write = 1'b1;
            end
            OpJmp: begin
              strb.ir_oe   = 1'b1;
              strb.pc_load = 1'b1;
            end
`ifdef CTRL_JZ_EN
            OpJz: begin
              strb.ir_oe   = zero_flag;
              strb.pc_load = zero_flag;
            end
`endif
            OpOut: begin
              strb.a_oe      = 1'b1;
              strb.out_write = 1'b1;
            end
            default: ;
          endcase
        end
        StT3: begin
          case (opcode)
            OpLda: begin
              strb.ram_read = 1'b1;
              strb.a_write  = 1'b1;
            end
            OpAdd, OpSub: begin
              strb.ram_read = 1'b1;
              strb.b_write  = 1'b1;
            end
            OpSta: begin
              strb.a_oe      = 1'b1;
              strb.ram_write = 1'b1;
            end
            default: ;
          endcase
        end
        StT4: begin
          if (uses_t4(opcode)) begin
            strb.alu_oe  = 1'b1;
            strb.a_write = 1'b1;
            strb.alu_sub = (opcode == OpSub);
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/ctrl_seq.sv
// Microcoded T-state sequencer for a simple accumulator machine.
// Optional feature macro: CTRL_JZ_EN (opcode 0x7 executes as JZ).
module ctrl_seq
  import ctrl_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        run,
  input  logic [15:0] ir_in,
  input  logic        zero_flag,
  output logic        pc_oe,
  output logic        pc_inc,
  output logic        pc_load,
  output logic        mar_write,
  output logic        ram_read,
  output logic        ram_write,
  output logic        ir_write,
  output logic        ir_oe,
  output logic        a_write,
  output logic        a_oe,
  output logic        b_write,
  output logic        alu_oe,
  output logic        alu_sub,
  output logic        out_write,
  output logic        halted,
  output logic [2:0]  tstate
);

  state_e     state_q, state_d;
  logic [3:0] opcode;
  strobes_t   strb;

  logic unused_operand;
  assign unused_operand = ^ir_in[11:0];

  assign opcode = ir_in[15:12];

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StT0;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      StT0:    state_d = run ? StT1 : StT0;
      StT1:    state_d = StT2;
      StT2: begin
        if (opcode == OpHlt) begin
          state_d = StHalt;
        end else if (uses_t3(opcode)) begin
          state_d = StT3;
        end else begin
          state_d = StT0;
        end
      end
      StT3:    state_d = uses_t4(opcode) ? StT4 : StT0;
      StT4:    state_d = StT0;
      StHalt:  state_d = StHalt;
      default: state_d = StT0;
    endcase
  end

  ctrl_decode u_decode (
    .state     (state_q),
    .opcode    (opcode),
    .run       (run),
    .rst       (rst),
    .zero_flag (zero_flag),
    .strb      (strb)
  );

  assign pc_oe     = strb.pc_oe;
  assign pc_inc    = strb.pc_inc;
  assign pc_load   = strb.pc_load;
  assign mar_write = strb.mar_write;
  assign ram_read  = strb.ram_read;
  assign ram_write = strb.ram_write;
  assign ir_write  = strb.ir_write;
  assign ir_oe     = strb.ir_oe;
  assign a_write   = strb.a_write;
  assign a_oe      = strb.a_oe;
  assign b_write   = strb.b_write;
  assign alu_oe    = strb.alu_oe;
  assign alu_sub   = strb.alu_sub;
  assign out_write = strb.out_write;

  assign halted = (state_q == StHalt);
  assign tstate = state_q;

endmodule

// File: tb/tb_ctrl_seq.sv
// Table-driven bench for ctrl_seq: one row per clock cycle plus timed sequences.
// Honours CTRL_JZ_EN the same way the design does.
module tb_ctrl_seq;

  logic        clk = 1'b0;
  logic        rst, run, zero_flag;
  logic [15:0] ir_in;
  logic pc_oe, pc_inc, pc_load, mar_write, ram_read, ram_write, ir_write, ir_oe;
  logic a_write, a_oe, b_write, alu_oe, alu_sub, out_write, halted;
  logic [2:0]  tstate;

  always #5 clk = ~clk;

  ctrl_seq dut (
    .clk       (clk),
    .rst       (rst),
    .run       (run),
    .ir_in     (ir_in),
    .zero_flag (zero_flag),
    .pc_oe     (pc_oe),
    .pc_inc    (pc_inc),
    .pc_load   (pc_load),
    .mar_write (mar_write),
    .ram_read  (ram_read),
    .ram_write (ram_write),
    .ir_write  (ir_write),
    .ir_oe     (ir_oe),
    .a_write   (a_write),
    .a_oe      (a_oe),
    .b_write   (b_write),
    .alu_oe    (alu_oe),
    .alu_sub   (alu_sub),
    .out_write (out_write),
    .halted    (halted),
    .tstate    (tstate)
  );

  localparam logic [13:0] PC_OE = 14'h2000, PC_INC = 14'h1000, PC_LD = 14'h0800;
  localparam logic [13:0] MAR_W = 14'h0400, RAM_R = 14'h0200, RAM_W = 14'h0100;
  localparam logic [13:0] IR_W = 14'h0080, IR_OE = 14'h0040, A_W = 14'h0020;
  localparam logic [13:0] A_OE = 14'h0010, B_W = 14'h0008, ALU_OE = 14'h0004;
  localparam logic [13:0] ALU_SUB = 14'h0002, OUT_W = 14'h0001;

`ifdef CTRL_JZ_EN
  localparam logic [13:0] JZ_TAKEN = IR_OE | PC_LD;
`else
  localparam logic [13:0] JZ_TAKEN = 14'h0000;
`endif

  typedef struct {
    logic        rst;
    logic        run;
    logic [15:0] ir;
    logic        zf;
    logic [2:0]  st;
    logic [13:0] strb;
    logic        halted;
  } vec_t;

  vec_t vecs[$];
  int   checks = 0;
  int   passed = 0;

  function automatic logic [13:0] strobes_now();
    return {pc_oe, pc_inc, pc_load, mar_write, ram_read, ram_write, ir_write, ir_oe,
            a_write, a_oe, b_write, alu_oe, alu_sub, out_write};
  endfunction

  task automatic check(input string name, input int row, input logic [15:0] act,
                       input logic [15:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s row %0d: got 0x%0h expected 0x%0h", name, row, act, exp);
  endtask

  task automatic add(input logic r, input logic rn, input logic [15:0] ir, input logic zf,
                     input logic [2:0] st, input logic [13:0] s, input logic h);
    vec_t v;
    v.rst = r; v.run = rn; v.ir = ir; v.zf = zf; v.st = st; v.strb = s; v.halted = h;
    vecs.push_back(v);
  endtask

  task automatic fetch(input logic [15:0] ir, input logic zf);
    add(0, 1, ir, zf, 3'd0, PC_OE | MAR_W, 0);
    add(0, 1, ir, zf, 3'd1, RAM_R | IR_W | PC_INC, 0);
  endtask

  task automatic timed(input string name, input logic [15:0] ir, input int exp_cycles);
    int n = 0;
    @(negedge clk);
    ir_in = ir; run = 1'b1;
    do begin
      @(posedge clk);
      #1;
      n++;
    end while (tstate != 3'd0 && n < 10);
    check(name, 0, 16'(n), 16'(exp_cycles));
  endtask

  initial begin
    rst = 1'b1; run = 1'b0; ir_in = 16'h0; zero_flag = 1'b0;

    add(1, 1, 16'h1005, 0, 3'd0, 14'h0, 0);                 // reset overrides T0 decode
    fetch(16'h1005, 0);                                      // LDA
    add(0, 1, 16'h1005, 0, 3'd2, IR_OE | MAR_W, 0);
    add(0, 1, 16'h1005, 0, 3'd3, RAM_R | A_W, 0);
    fetch(16'h2008, 0);                                      // ADD
    add(0, 1, 16'h2008, 0, 3'd2, IR_OE | MAR_W, 0);
    add(0, 1, 16'h2008, 0, 3'd3, RAM_R | B_W, 0);
    add(0, 1, 16'h2008, 0, 3'd4, ALU_OE | A_W, 0);
    fetch(16'h3008, 0);                                      // SUB
    add(0, 1, 16'h3008, 0, 3'd2, IR_OE | MAR_W, 0);
    add(0, 1, 16'h3008, 0, 3'd3, RAM_R | B_W, 0);
    add(0, 1, 16'h3008, 0, 3'd4, ALU_OE | A_W | ALU_SUB, 0);
    for (int i = 0; i < 4; i++) add(0, 0, 16'h1005, 0, 3'd0, 14'h0, 0);
    fetch(16'h4000, 0);                                      // STA
    add(0, 1, 16'h4000, 0, 3'd2, IR_OE | MAR_W, 0);
    add(0, 1, 16'h4000, 0, 3'd3, A_OE | RAM_W, 0);
    fetch(16'h5000, 0);                                      // LDI
    add(0, 1, 16'h5000, 0, 3'd2, IR_OE | A_W, 0);
    fetch(16'h6000, 0);                                      // JMP
    add(0, 1, 16'h6000, 0, 3'd2, IR_OE | PC_LD, 0);
    fetch(16'hE000, 0);                                      // OUT
    add(0, 1, 16'hE000, 0, 3'd2, A_OE | OUT_W, 0);
    fetch(16'h0000, 0);                                      // NOP
    add(0, 1, 16'h0000, 0, 3'd2, 14'h0, 0);
    fetch(16'h9000, 0);                                      // unused opcode
    add(0, 1, 16'h9000, 0, 3'd2, 14'h0, 0);
    fetch(16'h7010, 1);                                      // JZ taken
    add(0, 1, 16'h7010, 1, 3'd2, JZ_TAKEN, 0);
    fetch(16'h7010, 0);                                      // JZ not taken
    add(0, 1, 16'h7010, 0, 3'd2, 14'h0, 0);
    fetch(16'h2008, 0);                                      // ADD aborted in T3
    add(0, 1, 16'h2008, 0, 3'd2, IR_OE | MAR_W, 0);
    add(1, 1, 16'h2008, 0, 3'd3, 14'h0, 0);
    add(0, 0, 16'h2008, 0, 3'd0, 14'h0, 0);
    fetch(16'hF000, 0);                                      // HLT
    add(0, 1, 16'hF000, 0, 3'd2, 14'h0, 0);
    add(0, 1, 16'hF000, 0, 3'd5, 14'h0, 1);
    add(0, 0, 16'hF000, 0, 3'd5, 14'h0, 1);
    add(0, 1, 16'hF000, 0, 3'd5, 14'h0, 1);
    add(1, 1, 16'hF000, 0, 3'd5, 14'h0, 1);
    add(0, 0, 16'hF000, 0, 3'd0, 14'h0, 0);

    @(posedge clk);
    for (int i = 0; i < vecs.size(); i++) begin
      @(negedge clk);
      rst = vecs[i].rst; run = vecs[i].run; ir_in = vecs[i].ir; zero_flag = vecs[i].zf;
      #1;
      check("tstate", i, 16'(tstate), 16'(vecs[i].st));
      check("strobes", i, 16'(strobes_now()), 16'(vecs[i].strb));
      check("halted", i, 16'(halted), 16'(vecs[i].halted));
      check("one_driver", i, 16'($countones({pc_oe, ir_oe, a_oe, alu_oe, ram_read}) <= 1),
            16'd1);
    end

    timed("add_cycles", 16'h2008, 5);
    timed("sub_cycles", 16'h3008, 5);
    timed("lda_cycles", 16'h1005, 4);
    timed("ldi_cycles", 16'h5000, 3);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
